// File: rtl/fan_pkg.sv
// Shared fan-tree package: default geometry, index-width helper, collector
// state encoding and the result record handed to the write-back buffer.
package fan_pkg;

    localparam int unsigned DW_DATA  = 8;
    localparam int unsigned N        = 32;
    localparam int unsigned N_ADDERS = N - 1;

    // Index width for n adders; never less than one bit.
    function automatic int unsigned fan_idx_w(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    typedef enum logic {
        IDLE,
        DRAIN
    } fan_state_t;

    typedef struct packed {
        logic [2*DW_DATA-1:0]        data;
        logic [fan_idx_w(N_ADDERS)-1:0] idx;
        logic                        last;
    } fan_result_t;

endpackage

// File: rtl/fan_out_collector_if.sv
// Handshake bundle between fan_tree, the collector and the write-back buffer.
// slave: collector side (consumes vectors, produces results); master: the
// opposite side.
interface fan_out_collector_if
    import fan_pkg::*;
#(
    parameter int unsigned DW_DATA  = fan_pkg::DW_DATA,
    parameter int unsigned N_ADDERS = fan_pkg::N_ADDERS,
    parameter int unsigned DW_IDX   = fan_pkg::fan_idx_w(N_ADDERS)
);

    logic                            in_valid;
    logic                            in_ready;
    logic [2*DW_DATA*N_ADDERS-1:0]   in_data;
    logic [N_ADDERS-1:0]             in_mask;
    logic                            in_last;

    logic                            out_valid;
    logic                            out_ready;
    logic [2*DW_DATA-1:0]            out_data;
    logic [DW_IDX-1:0]               out_idx;
    logic                            out_last;

    modport slave (
        input  in_valid, in_data, in_mask, in_last, out_ready,
        output in_ready, out_valid, out_data, out_idx, out_last
    );

    modport master (
        output in_valid, in_data, in_mask, in_last, out_ready,
        input  in_ready, out_valid, out_data, out_idx, out_last
    );

endinterface

// File: rtl/fan_prio_enc.sv
// Lowest-set-bit priority encoder: index, found flag and one-hot of the
// winning bit. Shared with fan_tree configuration generation.
module fan_prio_enc
    import fan_pkg::*;
#(
    parameter int unsigned W  = fan_pkg::N_ADDERS,
    parameter int unsigned IW = fan_pkg::fan_idx_w(W)
) (
    input  logic [W-1:0]  vec,
    output logic [IW-1:0] idx,
    output logic          found,
    output logic [W-1:0]  onehot
);

    // Scan from the top down so the lowest set bit wins.
    always_comb begin
        idx    = '0;
        found  = |vec;
        onehot = vec & (~vec + W'(1));
        for (int unsigned i = W; i > 0; i--) begin
            if (vec[i-1]) idx = IW'(i - 1);
        end
    end

endmodule

// File: rtl/fan_out_collector.sv
// fan_out_collector: serializes the finished cluster sums of one fan_tree
// reduction vector, lowest adder index first, one result per cycle.
// Build option FAN_COLLECT_RELU_EN: clamp negative (signed) sums to zero.
module fan_out_collector
    import fan_pkg::*;
#(
    parameter int unsigned DW_DATA  = fan_pkg::DW_DATA,
    parameter int unsigned N_ADDERS = fan_pkg::N_ADDERS,
    parameter int unsigned DW_IDX   = fan_pkg::fan_idx_w(N_ADDERS)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    fan_out_collector_if.slave   bus,
    output logic [15:0]          result_cnt
);

    localparam int unsigned DW_SUM = 2 * DW_DATA;

    fan_state_t                     state, state_nxt;
    logic [DW_SUM*N_ADDERS-1:0]     data_r;
    logic [N_ADDERS-1:0]            mask_r;
    logic                           last_r;

    logic [DW_IDX-1:0]              enc_idx;
    logic                           enc_found;
    logic [N_ADDERS-1:0]            enc_onehot;

    logic                           slot_free;
    logic                           single;
    logic                           emit;
    logic                           accept;
    logic [DW_SUM-1:0]              sel_sum;
    logic [DW_SUM-1:0]              res_data;

    fan_prio_enc #(
        .W  (N_ADDERS),
        .IW (DW_IDX)
    ) u_prio_enc (
        .vec    (mask_r),
        .idx    (enc_idx),
        .found  (enc_found),
        .onehot (enc_onehot)
    );

    assign slot_free = !bus.out_valid || bus.out_ready;
    assign single    = enc_found && (enc_onehot == mask_r);
    assign accept    = bus.in_valid && bus.in_ready;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next state: leave DRAIN after the final bit unless a fresh nonzero
    // vector is taken on that same edge.
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: if (accept && |bus.in_mask) state_nxt = DRAIN;
            DRAIN: if (emit && single) state_nxt = (accept && |bus.in_mask) ? DRAIN : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // FSM outputs: emit a result when a slot is free; accept a new vector
    // while idle or while the last remaining bit goes out.
    always_comb begin
        emit         = (state == DRAIN) && slot_free;
        bus.in_ready = (state == IDLE) || (emit && single);
    end

    // One-hot mux of the selected adder output.
    always_comb begin
        sel_sum = '0;
        for (int unsigned i = 0; i < N_ADDERS; i++) begin
            if (enc_onehot[i]) sel_sum = data_r[i*DW_SUM +: DW_SUM];
        end
`ifdef FAN_COLLECT_RELU_EN
        res_data = sel_sum[DW_SUM-1] ? '0 : sel_sum;
`else
        res_data = sel_sum;
`endif
    end

    // Holding registers: load on accept, otherwise retire the emitted bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_r <= '0;
            mask_r <= '0;
            last_r <= 1'b0;
        end else if (accept) begin
            data_r <= bus.in_data;
            mask_r <= bus.in_mask;
            last_r <= bus.in_last;
        end else if (emit) begin
            mask_r <= mask_r & ~enc_onehot;
        end
    end

    // Output register: loads on emit, holds under backpressure.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.out_valid <= 1'b0;
            bus.out_data  <= '0;
            bus.out_idx   <= '0;
            bus.out_last  <= 1'b0;
        end else if (emit) begin
            bus.out_valid <= 1'b1;
            bus.out_data  <= res_data;
            bus.out_idx   <= enc_idx;
            bus.out_last  <= last_r && single;
        end else if (bus.out_ready) begin
            bus.out_valid <= 1'b0;
        end
    end

    // Saturating count of output handshakes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) result_cnt <= '0;
        else if (bus.out_valid && bus.out_ready && result_cnt != 16'hFFFF)
            result_cnt <= result_cnt + 16'd1;
    end

endmodule

// File: tb/tb_fan_out_collector.sv
// Directed bench for fan_out_collector with hand-computed expectations.
// Honours FAN_COLLECT_RELU_EN for the negative-sum vector.
module tb_fan_out_collector;
    import fan_pkg::*;

    logic        clk;
    logic        rst_n;
    logic [15:0] result_cnt;
    int          errors;
    int          checks;

    fan_out_collector_if #(.DW_DATA(8), .N_ADDERS(31), .DW_IDX(5)) bus ();

    fan_out_collector #(
        .DW_DATA  (8),
        .N_ADDERS (31),
        .DW_IDX   (5)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus        (bus.slave),
        .result_cnt (result_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    // Advance one rising edge and settle just after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_out(input string tag, input logic v, input logic [15:0] d,
                             input logic [4:0] idx, input logic last);
        check({tag, ".valid"}, 32'(bus.out_valid), 32'(v));
        check({tag, ".data"},  32'(bus.out_data),  32'(d));
        check({tag, ".idx"},   32'(bus.out_idx),   32'(idx));
        check({tag, ".last"},  32'(bus.out_last),  32'(last));
    endtask

    task automatic fill_ramp();
        for (int i = 0; i < 31; i++) bus.in_data[i*16 +: 16] = 16'(i + 1);
    endtask

    task automatic do_reset();
        bus.in_valid  = 1'b0;
        bus.in_mask   = '0;
        bus.in_last   = 1'b0;
        bus.out_ready = 1'b1;
        fill_ramp();
        rst_n = 1'b0;
        repeat (2) step();
        rst_n = 1'b1;
        step();
    endtask

    initial begin
        errors = 0;
        checks = 0;
        bus.in_data = '0;
        do_reset();
        check("rst.in_ready", 32'(bus.in_ready), 32'd1);
        check_out("rst.out", 1'b0, 16'h0, 5'd0, 1'b0);
        check("rst.cnt", 32'(result_cnt), 32'd0);

        // Basic order: mask 101, last set, no backpressure.
        bus.in_mask  = 31'b101;
        bus.in_last  = 1'b1;
        bus.in_valid = 1'b1;
        step();                                     // edge k: accepted
        bus.in_valid = 1'b0;
        check("basic.k.valid", 32'(bus.out_valid), 32'd0);
        check("basic.k.in_ready", 32'(bus.in_ready), 32'd0);
        step();                                     // k+1
        check_out("basic.r0", 1'b1, 16'd1, 5'd0, 1'b0);
        step();                                     // k+2
        check_out("basic.r1", 1'b1, 16'd3, 5'd2, 1'b1);
        check("basic.k2.in_ready", 32'(bus.in_ready), 32'd1);
        step();
        check("basic.drained", 32'(bus.out_valid), 32'd0);
        check("basic.cnt", 32'(result_cnt), 32'd2);

        // Backpressure: out_ready low for 3 cycles once the first result shows.
        do_reset();
        bus.out_ready = 1'b0;
        bus.in_mask   = 31'b101;
        bus.in_last   = 1'b1;
        bus.in_valid  = 1'b1;
        step();
        bus.in_valid = 1'b0;
        step();
        for (int c = 0; c < 3; c++) begin
            check_out("bp.hold", 1'b1, 16'd1, 5'd0, 1'b0);
            check("bp.in_ready", 32'(bus.in_ready), 32'd0);
            step();
        end
        check_out("bp.hold3", 1'b1, 16'd1, 5'd0, 1'b0);
        bus.out_ready = 1'b1;
        #1;
        check("bp.release.in_ready", 32'(bus.in_ready), 32'd1);
        step();
        check_out("bp.r1", 1'b1, 16'd3, 5'd2, 1'b1);
        step();
        check("bp.drained", 32'(bus.out_valid), 32'd0);
        check("bp.cnt", 32'(result_cnt), 32'd2);

        // Back-to-back: mask 1 then mask 110 with no gap.
        do_reset();
        bus.in_last  = 1'b0;
        bus.in_mask  = 31'b1;
        bus.in_valid = 1'b1;
        step();                                     // vector 1 accepted
        bus.in_mask = 31'b110;
        #1;
        check("b2b.in_ready", 32'(bus.in_ready), 32'd1);
        step();                                     // vector 2 accepted, idx0 out
        bus.in_valid = 1'b0;
        check_out("b2b.r0", 1'b1, 16'd1, 5'd0, 1'b0);
        check("b2b.busy", 32'(bus.in_ready), 32'd0);
        step();
        check_out("b2b.r1", 1'b1, 16'd2, 5'd1, 1'b0);
        step();
        check_out("b2b.r2", 1'b1, 16'd3, 5'd2, 1'b0);
        step();
        check("b2b.drained", 32'(bus.out_valid), 32'd0);
        check("b2b.cnt", 32'(result_cnt), 32'd3);

        // Empty mask with last: dropped silently.
        do_reset();
        bus.in_mask  = '0;
        bus.in_last  = 1'b1;
        bus.in_valid = 1'b1;
        #1;
        check("empty.in_ready", 32'(bus.in_ready), 32'd1);
        step();
        bus.in_valid = 1'b0;
        check("empty.valid0", 32'(bus.out_valid), 32'd0);
        check("empty.ready_after", 32'(bus.in_ready), 32'd1);
        step();
        check("empty.valid1", 32'(bus.out_valid), 32'd0);
        check("empty.cnt", 32'(result_cnt), 32'd0);

        // Reset mid-drain after 4 handshakes of an all-ones vector.
        do_reset();
        bus.in_mask  = '1;
        bus.in_last  = 1'b1;
        bus.in_valid = 1'b1;
        step();
        bus.in_valid = 1'b0;
        repeat (5) step();                          // idx0..3 handshaken, idx4 shown
        check_out("mid.r4", 1'b1, 16'd5, 5'd4, 1'b0);
        check("mid.cnt4", 32'(result_cnt), 32'd4);
        rst_n = 1'b0;
        #1;
        check_out("mid.rst", 1'b0, 16'h0, 5'd0, 1'b0);
        check("mid.rst.cnt", 32'(result_cnt), 32'd0);
        step();
        rst_n = 1'b1;
        step();
        check("mid.in_ready", 32'(bus.in_ready), 32'd1);
        for (int c = 0; c < 3; c++) begin
            check("mid.no_stale", 32'(bus.out_valid), 32'd0);
            step();
        end
        check("mid.cnt", 32'(result_cnt), 32'd0);

        // Negative sum at adder 3.
        do_reset();
        bus.in_data[3*16 +: 16] = 16'hFFF6;
        bus.in_mask  = 31'b1000;
        bus.in_last  = 1'b0;
        bus.in_valid = 1'b1;
        step();
        bus.in_valid = 1'b0;
        step();
`ifdef FAN_COLLECT_RELU_EN
        check_out("relu", 1'b1, 16'h0000, 5'd3, 1'b0);
`else
        check_out("relu", 1'b1, 16'hFFF6, 5'd3, 1'b0);
`endif
        step();
        check("relu.cnt", 32'(result_cnt), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
